gb_instr_feeder: RTL and testbench

Byte-stream-to-instruction issuer that drives the gbprocessor's `instruction`/`data`/`valid` inputs. It accepts a flat stream of program bytes from a host or memory port, buffers them in a small FIFO, and decodes the 8-bit load-immediate opcodes. Each opcode, with its immediate byte where the opcode takes one, is then issued to the processor as a single-cycle `valid` beat. The feeder sits directly upstream of the processor and is the producer end of its instruction interface.

---
 rtl/gb_instr_feeder.sv | 146 ++++++++++++++
 tb/tb_gb_instr_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_instr_feeder.sv
// gb_instr_feeder: buffers a program byte stream in a small FIFO, decodes
// load-immediate opcodes and issues one single-cycle valid beat per
// complete instruction to the gbprocessor.
// Optional feature macro: GB_INSTR_FEEDER_COUNT_EN adds the issue_count port.
module gb_instr_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        halt,
  output logic [7:0]  instruction,
  output logic [7:0]  data,
  output logic        valid,
  output logic        busy
`ifdef GB_INSTR_FEEDER_COUNT_EN
  ,
  output logic [15:0] issue_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_OP, ST_IMM} state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  state_t      r_state;
  logic [7:0]  r_op_hold;
  logic [7:0]  r_instruction;
  logic [7:0]  r_data;
  logic        r_valid;

  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic [7:0]  w_head;
  state_t      w_state_nxt;
  logic        w_pop;
  logic        w_issue;
  logic        w_hold_load;
  logic [7:0]  w_instr_nxt;
  logic [7:0]  w_data_nxt;

  // Load-immediate opcodes: 00_rrr_110 except rrr=110 (the (HL) form).
  function automatic logic f_is_imm(input logic [7:0] b);
    return (b[7:6] == 2'b00) && (b[2:0] == 3'b110) && (b[5:3] != 3'b110);
  endfunction

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign in_ready = ~reset & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign busy     = ~reset & (~w_empty | (r_state == ST_IMM));

  assign instruction = r_instruction;
  assign data        = r_data;
  assign valid       = r_valid;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_byte;
  end

  // FIFO pointers; a full FIFO never accepts, so a pop cannot make room in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_OP;
    else       r_state <= w_state_nxt;
  end

  // Next-state and issue decision; the byte popped in IMM is never decoded.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_hold_load = 1'b0;
    w_instr_nxt = r_instruction;
    w_data_nxt  = r_data;
    if (!w_empty && !halt) begin
      w_pop = 1'b1;
      if (r_state == ST_OP) begin
        if (f_is_imm(w_head)) begin
          w_hold_load = 1'b1;
          w_state_nxt = ST_IMM;
        end else begin
          w_issue     = 1'b1;
          w_instr_nxt = w_head;
          w_data_nxt  = 8'h00;
        end
      end else begin
        w_issue     = 1'b1;
        w_instr_nxt = r_op_hold;
        w_data_nxt  = w_head;
        w_state_nxt = ST_OP;
      end
    end
  end

  // Opcode holding register; only meaningful while in IMM, so not reset.
  always_ff @(posedge clock) begin
    if (w_hold_load) r_op_hold <= w_head;
  end

  // Registered issue outputs; instruction/data hold between issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_instruction <= 8'h00;
      r_data        <= 8'h00;
      r_valid       <= 1'b0;
    end else begin
      r_instruction <= w_instr_nxt;
      r_data        <= w_data_nxt;
      r_valid       <= w_issue;
    end
  end

`ifdef GB_INSTR_FEEDER_COUNT_EN
  logic [15:0] r_issue_count;

  // Issue counter, updated on the same edge as valid; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset)        r_issue_count <= 16'h0000;
    else if (w_issue) r_issue_count <= r_issue_count + 16'h0001;
  end

  assign issue_count = r_issue_count;
`endif

endmodule

// File: tb/tb_gb_instr_feeder.sv
// Testbench for gb_instr_feeder: directed scenarios with literal
// expectations plus randomized traffic against a queue-based model.
module tb_gb_instr_feeder;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        halt = 1'b0;
  logic [7:0]  instruction;
  logic [7:0]  data;
  logic        valid;
  logic        busy;
`ifdef GB_INSTR_FEEDER_COUNT_EN
  logic [15:0] issue_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  gb_instr_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .halt        (halt),
    .instruction (instruction),
    .data        (data),
    .valid       (valid),
    .busy        (busy)
`ifdef GB_INSTR_FEEDER_COUNT_EN
    ,
    .issue_count (issue_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned q[$];
  bit           m_have_op = 0;
  logic [7:0]   m_op = 8'h00;
  logic [7:0]   m_instr = 8'h00;
  logic [7:0]   m_data = 8'h00;
  logic         m_valid = 1'b0;
  logic [15:0]  m_cnt = 16'h0000;

  function automatic bit is_imm_op(input logic [7:0] b);
    return b inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E};
  endfunction

  // Compare process: pre-edge combinational outputs, model step, post-edge registered outputs.
  always @(posedge clock) begin
    logic       exp_rdy;
    logic [7:0] b;
    exp_rdy = !reset && (q.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("busy", {31'd0, busy}, {31'd0, !reset && (q.size() > 0 || m_have_op)});
    if (reset) begin
      q.delete();
      m_have_op = 0;
      m_instr = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_cnt = 16'h0000;
    end else begin
      m_valid = 1'b0;
      if (q.size() > 0 && !halt) begin
        b = q.pop_front();
        if (m_have_op) begin
          m_instr = m_op; m_data = b; m_valid = 1'b1; m_have_op = 0;
        end else if (is_imm_op(b)) begin
          m_op = b; m_have_op = 1;
        end else begin
          m_instr = b; m_data = 8'h00; m_valid = 1'b1;
        end
        if (m_valid) m_cnt = m_cnt + 16'd1;
      end
      if (in_valid && exp_rdy) q.push_back(in_byte);
    end
    #1;
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("instruction", {24'd0, instruction}, {24'd0, m_instr});
    chk("data", {24'd0, data}, {24'd0, m_data});
`ifdef GB_INSTR_FEEDER_COUNT_EN
    chk("issue_count", {16'd0, issue_count}, {16'd0, m_cnt});
`endif
  end

  // One cycle: drive at negedge, return just after the consuming edge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic h);
    @(negedge clock);
    in_valid = v; in_byte = b; halt = h;
    @(posedge clock);
    #2;
  endtask

  task automatic out_is(input string name, input logic v, input logic [7:0] ins, input logic [7:0] d);
    chk({name, "_valid"}, {31'd0, valid}, {31'd0, v});
    if (v) begin
      chk({name, "_instr"}, {24'd0, instruction}, {24'd0, ins});
      chk({name, "_data"}, {24'd0, data}, {24'd0, d});
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; in_valid = 1'b0; halt = 1'b0;
    @(posedge clock); #2;
    chk("rst_instr", {24'd0, instruction}, 32'h0);
    chk("rst_data", {24'd0, data}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single-byte stream
    cyc(1, 8'h80, 0);
    cyc(1, 8'h47, 0);
    out_is("sb1", 1, 8'h80, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("sb2", 1, 8'h47, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("sb_idle", 0, 8'h00, 8'h00);
    chk("sb_hold", {24'd0, instruction}, 32'h47);

    // Immediate pair, then immediate byte that looks like an opcode
    cyc(1, 8'h3E, 0);
    cyc(1, 8'hA5, 0);
    out_is("imm_op", 0, 8'h00, 8'h00);
    cyc(1, 8'h06, 0);
    out_is("imm1", 1, 8'h3E, 8'hA5);
    cyc(1, 8'h0E, 0);
    out_is("imm2a", 0, 8'h00, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("imm2", 1, 8'h06, 8'h0E);
    cyc(0, 8'h00, 0);
    out_is("imm2_idle", 0, 8'h00, 8'h00);

    // Full / backpressure under halt
    cyc(1, 8'h10, 1);
    cyc(1, 8'h20, 1);
    cyc(1, 8'h40, 1);
    cyc(1, 8'h50, 1);
    chk("full_rdy", {31'd0, in_ready}, 32'h0);
    cyc(1, 8'h60, 1);
    cyc(1, 8'h70, 1);
    chk("full_busy", {31'd0, busy}, 32'h1);
    cyc(0, 8'h00, 0);
    out_is("bp1", 1, 8'h10, 8'h00);
    chk("bp_rdy_back", {31'd0, in_ready}, 32'h1);
    cyc(0, 8'h00, 0);
    out_is("bp2", 1, 8'h20, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("bp3", 1, 8'h40, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("bp4", 1, 8'h50, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("bp_end", 0, 8'h00, 8'h00);

    // Halt between opcode and immediate
    cyc(1, 8'h16, 0);
    cyc(0, 8'h00, 0);
    cyc(1, 8'h33, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 1);
      out_is("halt_hold", 0, 8'h00, 8'h00);
      chk("halt_busy", {31'd0, busy}, 32'h1);
    end
    cyc(0, 8'h00, 0);
    out_is("halt_rel", 1, 8'h16, 8'h33);

    // Reset mid-immediate
    cyc(1, 8'h26, 0);
    cyc(0, 8'h00, 0);
    do_reset();
    cyc(1, 8'h90, 0);
    out_is("rst_mid_a", 0, 8'h00, 8'h00);
    cyc(0, 8'h00, 0);
    out_is("rst_mid", 1, 8'h90, 8'h00);
    cyc(0, 8'h00, 0);

`ifdef GB_INSTR_FEEDER_COUNT_EN
    do_reset();
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 0);
    cyc(0, 8'h00, 0);
    chk("cnt3", {16'd0, issue_count}, 32'd3);
    @(negedge clock);
    force dut.r_issue_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release dut.r_issue_count;
    cyc(1, 8'h04, 0);
    cyc(0, 8'h00, 0);
    chk("cnt_wrap", {16'd0, issue_count}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] rb;
      @(negedge clock);
      reset = ($urandom_range(0, 99) == 0);
      halt  = ($urandom_range(0, 4) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 6))
          0: rb = 8'h06; 1: rb = 8'h0E; 2: rb = 8'h16; 3: rb = 8'h1E;
          4: rb = 8'h26; 5: rb = 8'h2E; default: rb = 8'h3E;
        endcase
      end else begin
        rb = 8'($urandom);
      end
      in_byte = rb;
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; halt = 1'b0;
    repeat (12) @(posedge clock);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
